// File: rtl/ram_bus_sequencer_if.sv
//----------------------------------------------------------------------------
// Module  : ram_bus_sequencer_if
// Brief   : Core request port plus RAM/ram_plexer bus for ram_bus_sequencer.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

interface ram_bus_sequencer_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
);
  logic              req_i;
  logic              we_i;
  logic [ADDR_W-1:0] addr_i;
  logic [DATA_W-1:0] wdata_i;
  logic              busy_o;
  logic              done_o;
  logic              err_o;
  logic [DATA_W-1:0] rdata_o;
  logic              rw_switch_o;
  logic [DATA_W-1:0] tx_data_o;
  logic [DATA_W-1:0] rx_data_i;
  logic [ADDR_W-1:0] ram_addr_o;
  logic              ram_cs_o;
  logic              ram_we_o;
  logic              ram_strobe_o;
  logic              ram_ack_i;

  // master: the core and the RAM side that surround the sequencer
  modport master (
    output req_i, we_i, addr_i, wdata_i, rx_data_i, ram_ack_i,
    input  busy_o, done_o, err_o, rdata_o, rw_switch_o, tx_data_o,
           ram_addr_o, ram_cs_o, ram_we_o, ram_strobe_o
  );

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, rx_data_i, ram_ack_i,
    output busy_o, done_o, err_o, rdata_o, rw_switch_o, tx_data_o,
           ram_addr_o, ram_cs_o, ram_we_o, ram_strobe_o
  );
endinterface

`default_nettype wire

// File: rtl/ram_bus_sequencer.sv
//----------------------------------------------------------------------------
// Module  : ram_bus_sequencer
// Brief   : Runs one core load/store at a time onto the shared RAM bus.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module ram_bus_sequencer #(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 32,
  parameter int SETUP_CYCLES = 1,
  parameter int TIMEOUT      = 15
) (
  input wire                 clk_i,
  input wire                 rst_i,
  ram_bus_sequencer_if.slave bus
);

  localparam int CNT_MAX = (SETUP_CYCLES > TIMEOUT) ? SETUP_CYCLES : TIMEOUT;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_SETUP  = 2'd1,
    S_STROBE = 2'd2,
    S_TURN   = 2'd3
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              we_q;
  logic              busy_q;
  logic              done_q;
  logic              err_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rw_switch_q;
  logic [DATA_W-1:0] tx_data_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic              ram_cs_q;
  logic              ram_we_q;
  logic              ram_strobe_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      we_q         <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      rdata_q      <= '0;
      rw_switch_q  <= 1'b0;
      tx_data_q    <= '0;
      ram_addr_q   <= '0;
      ram_cs_q     <= 1'b0;
      ram_we_q     <= 1'b0;
      ram_strobe_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          err_q <= 1'b0;
          if (bus.req_i) begin
            state_q     <= S_SETUP;
            cnt_q       <= CNT_W'(1);
            we_q        <= bus.we_i;
            ram_addr_q  <= bus.addr_i;
            tx_data_q   <= bus.wdata_i;
            busy_q      <= 1'b1;
            ram_cs_q    <= 1'b1;
            ram_we_q    <= bus.we_i;
            rw_switch_q <= bus.we_i;
          end
        end
        S_SETUP: begin
          if (cnt_q == CNT_W'(SETUP_CYCLES)) begin
            state_q      <= S_STROBE;
            cnt_q        <= CNT_W'(1);
            ram_strobe_q <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_STROBE: begin
          // An ack on the final allowed cycle still completes successfully.
          if (bus.ram_ack_i || (cnt_q == CNT_W'(TIMEOUT))) begin
            state_q      <= S_TURN;
            done_q       <= 1'b1;
            err_q        <= ~bus.ram_ack_i;
            ram_cs_q     <= 1'b0;
            ram_we_q     <= 1'b0;
            rw_switch_q  <= 1'b0;
            ram_strobe_q <= 1'b0;
            if (bus.ram_ack_i && !we_q) begin
              rdata_q <= bus.rx_data_i;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_TURN: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
          err_q   <= 1'b0;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.busy_o       = busy_q;
  assign bus.done_o       = done_q;
  assign bus.err_o        = err_q;
  assign bus.rdata_o      = rdata_q;
  assign bus.rw_switch_o  = rw_switch_q;
  assign bus.tx_data_o    = tx_data_q;
  assign bus.ram_addr_o   = ram_addr_q;
  assign bus.ram_cs_o     = ram_cs_q;
  assign bus.ram_we_o     = ram_we_q;
  assign bus.ram_strobe_o = ram_strobe_q;

endmodule

`default_nettype wire

// File: tb/tb_ram_bus_sequencer.sv
//----------------------------------------------------------------------------
// Module  : tb_ram_bus_sequencer
// Brief   : Self-checking bench for ram_bus_sequencer against an access timeline model.
// Revision: 1.0
//----------------------------------------------------------------------------
`default_nettype none

module tb_ram_bus_sequencer;

  localparam int ADDR_W       = 5;
  localparam int DATA_W       = 32;
  localparam int SETUP_CYCLES = 1;
  localparam int TIMEOUT      = 15;

  logic clk = 1'b0;
  logic rst = 1'b1;

  ram_bus_sequencer_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  ram_bus_sequencer #(
    .ADDR_W       (ADDR_W),
    .DATA_W       (DATA_W),
    .SETUP_CYCLES (SETUP_CYCLES),
    .TIMEOUT      (TIMEOUT)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [DATA_W-1:0] exp_rdata;
  logic [ADDR_W-1:0] exp_addr;
  logic [DATA_W-1:0] exp_tx;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: observed=0x%08h expected=0x%08h", tag, $time, obs, exp);
    end
  endtask

  task automatic check_outputs(input logic busy, input logic cs, input logic strobe,
                               input logic we, input logic rw, input logic done,
                               input logic err, input logic err_valid);
    check_eq("busy_o",       32'(bus.busy_o),       32'(busy));
    check_eq("ram_cs_o",     32'(bus.ram_cs_o),     32'(cs));
    check_eq("ram_strobe_o", 32'(bus.ram_strobe_o), 32'(strobe));
    check_eq("ram_we_o",     32'(bus.ram_we_o),     32'(we));
    check_eq("rw_switch_o",  32'(bus.rw_switch_o),  32'(rw));
    check_eq("done_o",       32'(bus.done_o),       32'(done));
    if (err_valid) check_eq("err_o", 32'(bus.err_o), 32'(err));
    check_eq("ram_addr_o",   32'(bus.ram_addr_o),   32'(exp_addr));
    check_eq("tx_data_o",    32'(bus.tx_data_o),    32'(exp_tx));
    check_eq("rdata_o",      32'(bus.rdata_o),      32'(exp_rdata));
  endtask

  // Starts in an IDLE cycle (at a negedge) and ends at the negedge of the IDLE
  // cycle after TURN. ack_n is the strobe cycle carrying ack; 0 or >TIMEOUT means none.
  task automatic do_access(input logic we, input logic [ADDR_W-1:0] addr,
                           input logic [DATA_W-1:0] wdata, input int ack_n,
                           input logic [DATA_W-1:0] rx_val);
    logic              timeout;
    int                len;
    int                last;
    logic [DATA_W-1:0] new_rdata;
    timeout   = (ack_n < 1) || (ack_n > TIMEOUT);
    len       = timeout ? TIMEOUT : ack_n;
    last      = SETUP_CYCLES + len + 2;
    new_rdata = (!we && !timeout) ? rx_val : exp_rdata;

    bus.req_i     = 1'b1;
    bus.we_i      = we;
    bus.addr_i    = addr;
    bus.wdata_i   = wdata;
    bus.ram_ack_i = 1'($urandom);
    bus.rx_data_i = DATA_W'($urandom);

    for (int i = 1; i <= last; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (i == 1) begin
        exp_addr = addr;
        exp_tx   = wdata;
      end
      if (i <= SETUP_CYCLES) begin
        check_outputs(1'b1, 1'b1, 1'b0, we, we, 1'b0, 1'b0, 1'b0);
      end else if (i <= SETUP_CYCLES + len) begin
        check_outputs(1'b1, 1'b1, 1'b1, we, we, 1'b0, 1'b0, 1'b0);
      end else if (i == SETUP_CYCLES + len + 1) begin
        exp_rdata = new_rdata;
        check_outputs(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, timeout, 1'b1);
      end else begin
        check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end

      // Requests and field changes while busy must be ignored.
      bus.req_i   = (i == last) ? 1'b0 : 1'($urandom);
      bus.we_i    = 1'($urandom);
      bus.addr_i  = ADDR_W'($urandom);
      bus.wdata_i = DATA_W'($urandom);
      if (i > SETUP_CYCLES && i <= SETUP_CYCLES + len) begin
        bus.ram_ack_i = (i == SETUP_CYCLES + ack_n);
        bus.rx_data_i = bus.ram_ack_i ? rx_val : DATA_W'($urandom);
      end else begin
        bus.ram_ack_i = 1'($urandom);
        bus.rx_data_i = DATA_W'($urandom);
      end
    end
  endtask

  task automatic idle_cycles(input int k);
    for (int i = 0; i < k; i++) begin
      bus.req_i     = 1'b0;
      bus.ram_ack_i = 1'($urandom);
      @(posedge clk);
      @(negedge clk);
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic reset_mid_write();
    bus.req_i     = 1'b1;
    bus.we_i      = 1'b1;
    bus.addr_i    = ADDR_W'($urandom);
    bus.wdata_i   = DATA_W'($urandom);
    bus.ram_ack_i = 1'b0;
    for (int i = 0; i < SETUP_CYCLES + 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      bus.req_i = 1'b0;
    end
    check_eq("strobe_before_rst",    32'(bus.ram_strobe_o), 32'd1);
    check_eq("rw_switch_before_rst", 32'(bus.rw_switch_o),  32'd1);
    rst       = 1'b1;
    exp_rdata = '0;
    exp_addr  = '0;
    exp_tx    = '0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst = 1'b0;
  endtask

  initial begin
    bus.req_i     = 1'b0;
    bus.we_i      = 1'b0;
    bus.addr_i    = '0;
    bus.wdata_i   = '0;
    bus.rx_data_i = '0;
    bus.ram_ack_i = 1'b0;
    exp_rdata     = '0;
    exp_addr      = '0;
    exp_tx        = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_outputs(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b0;

    do_access(1'b1, 5'd5,  32'hDEADBEEF, 1, DATA_W'($urandom));
    do_access(1'b0, 5'd31, DATA_W'($urandom), 3, 32'h12345678);
    do_access(1'b0, 5'd7,  DATA_W'($urandom), 0, 32'hCAFEF00D);
    do_access(1'b0, 5'd9,  DATA_W'($urandom), TIMEOUT, 32'hA5A55A5A);
    do_access(1'b1, 5'd0,  32'h0F0F0F0F, TIMEOUT + 1, DATA_W'($urandom));
    idle_cycles(2);
    reset_mid_write();
    do_access(1'b0, 5'd3, DATA_W'($urandom), 2, 32'h55AA1234);

    for (int k = 0; k < 150; k++) begin
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
      do_access(1'($urandom), ADDR_W'($urandom), DATA_W'($urandom),
                int'($urandom_range(0, TIMEOUT + 2)), DATA_W'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
